// File: rtl/usb_crc_check_if.sv
// usb_crc_check_if: receive CRC checker bit-stream and result bundle.
// master drives packet strobes/bits; slave returns busy/done/flags/bit_cnt.
interface usb_crc_check_if #(
  parameter int CNT_W = 14
) ();
  logic             pkt_start;
  logic [2:0]       sel;
  logic             bit_valid;
  logic             bit_in;
  logic             pkt_end;
  logic             busy;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic             len_err;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output pkt_start, sel, bit_valid, bit_in, pkt_end,
    input  busy, done, crc_ok, crc_err, len_err, bit_cnt
  );

  modport slave (
    input  pkt_start, sel, bit_valid, bit_in, pkt_end,
    output busy, done, crc_ok, crc_err, len_err, bit_cnt
  );
endinterface

// File: rtl/usb_crc_check.sv
// usb_crc_check: USB receive CRC5/CRC16 residual and length checker.
// Ports: clk, rst_n (async low), bus (slave: strobes/bits in, results out).
module usb_crc_check #(
  parameter int MAX_DATA_BYTES = 1023,
  parameter int CNT_W = 14
) (
  input logic            clk,
  input logic            rst_n,
  usb_crc_check_if.slave bus
);
  localparam int MAX_BITS = MAX_DATA_BYTES * 8 + 16;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] TOK_CNT = CNT_W'(16);
  localparam logic [4:0]  POLY5  = 5'b00101;
  localparam logic [15:0] POLY16 = 16'h8005;
  localparam logic [4:0]  RES5   = 5'b01100;
  localparam logic [15:0] RES16  = 16'h800D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q;
  logic [4:0]       crc5_q, crc5_nx;
  logic [15:0]      crc16_q, crc16_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             ok_q, err_q, len_q;
  logic             ok_nx, err_nx, len_nx;
  logic             take, close;
  logic             fb5, fb16;
  logic             len_ok, res_ok, len_bad;

  assign take  = (state_q == RUN) && bus.bit_valid;
  assign close = (state_q == RUN) && bus.pkt_end;
  assign fb5   = bus.bit_in ^ crc5_q[4];
  assign fb16  = bus.bit_in ^ crc16_q[15];

  always_comb begin
    crc5_nx  = crc5_q;
    crc16_nx = crc16_q;
    cnt_nx   = cnt_q;
    if (take) begin
      crc5_nx  = {crc5_q[3:0], 1'b0} ^ (fb5 ? POLY5 : 5'd0);
      crc16_nx = {crc16_q[14:0], 1'b0} ^ (fb16 ? POLY16 : 16'd0);
      if (!(&cnt_q))
        cnt_nx = cnt_q + 1'b1;
    end
  end

  // Results judged on the post-bit values so a bit sharing
  // the pkt_end cycle is part of the packet.
  always_comb begin
    len_ok = 1'b0;
    res_ok = 1'b0;
    case (sel_q)
      3'b001: begin
        len_ok = (cnt_nx == TOK_CNT);
        res_ok = (crc5_nx == RES5);
      end
      3'b010: begin
        len_ok = (cnt_nx >= TOK_CNT) &&
                 (cnt_nx[2:0] == 3'd0) &&
                 (cnt_nx <= MAX_CNT);
        res_ok = (crc16_nx == RES16);
      end
      3'b100: begin
        len_ok = (cnt_nx == '0);
        res_ok = 1'b1;
      end
      default: begin
        len_ok = 1'b0;
        res_ok = 1'b0;
      end
    endcase
    len_bad = !len_ok || (&cnt_nx);
    ok_nx   = !len_bad && res_ok;
    err_nx  = !len_bad && !res_ok;
    len_nx  = len_bad;
  end

  always_comb begin
    state_d = state_q;
    if (bus.pkt_start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (bus.pkt_end) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'b000;
      crc5_q  <= 5'h1F;
      crc16_q <= 16'hFFFF;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.pkt_start) begin
        sel_q   <= bus.sel;
        crc5_q  <= 5'h1F;
        crc16_q <= 16'hFFFF;
        cnt_q   <= '0;
        ok_q    <= 1'b0;
        err_q   <= 1'b0;
        len_q   <= 1'b0;
      end else begin
        crc5_q  <= crc5_nx;
        crc16_q <= crc16_nx;
        cnt_q   <= cnt_nx;
        if (close) begin
          ok_q  <= ok_nx;
          err_q <= err_nx;
          len_q <= len_nx;
        end
      end
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.crc_ok  = ok_q;
  assign bus.crc_err = err_q;
  assign bus.len_err = len_q;
  assign bus.bit_cnt = cnt_q;
endmodule

// File: tb/tb_usb_crc_check.sv
// tb_usb_crc_check: directed + randomized bench for usb_crc_check.
// Reference packets use the reflected USB CRC form; expectations are arithmetic.
module tb_usb_crc_check;
  logic clk = 1'b0;
  logic rst_n;
  int   ntests = 0;
  int   nfail  = 0;
  int   ndone  = 0;
  bit   pk[$];

  usb_crc_check_if #(.CNT_W(14)) bus ();

  usb_crc_check #(
    .MAX_DATA_BYTES(1023),
    .CNT_W(14)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.done) ndone++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.crc_ok, bus.crc_err, bus.len_err};
  endfunction

  // {ok,err,len} from the length rules and whether the CRC field is intact
  function automatic logic [31:0] model(input logic [2:0] s, input int n,
                                        input bit good);
    bit legal;
    legal = 1'b0;
    case (s)
      3'b001:  legal = (n == 16);
      3'b010:  legal = (n >= 16) && (n % 8 == 0) && (n <= 1023 * 8 + 16);
      3'b100:  legal = (n == 0);
      default: legal = 1'b0;
    endcase
    if (n >= 16383) legal = 1'b0;
    if (!legal) return 32'b001;
    if (s == 3'b100 || good) return 32'b100;
    return 32'b010;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) pk.push_back(b[i]);
  endtask

  task automatic gen_data(input int nbytes);
    logic [15:0] c;
    logic [7:0]  b;
    pk.delete();
    c = 16'hFFFF;
    for (int k = 0; k < nbytes; k++) begin
      b = 8'($urandom);
      push_byte(b);
      for (int i = 0; i < 8; i++)
        c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    c = c ^ 16'hFFFF;
    for (int i = 0; i < 16; i++) pk.push_back(c[i]);
  endtask

  task automatic gen_token(input logic [10:0] f);
    logic [4:0] c;
    pk.delete();
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      pk.push_back(f[i]);
      c = (c[0] ^ f[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    end
    c = c ^ 5'h1F;
    for (int i = 0; i < 5; i++) pk.push_back(c[i]);
  endtask

  task automatic flip(input int k);
    int a, b;
    a = $urandom_range(0, pk.size() - 1);
    pk[a] = ~pk[a];
    if (k > 1 && pk.size() > 1) begin
      do b = $urandom_range(0, pk.size() - 1); while (b == a);
      pk[b] = ~pk[b];
    end
  endtask

  task automatic start(input logic [2:0] s);
    bus.pkt_start = 1'b1;
    bus.sel = s;
    tick();
    bus.pkt_start = 1'b0;
    bus.sel = 3'($urandom);
  endtask

  task automatic run_pkt(input logic [2:0] s, input int ncnt,
                         input logic [31:0] expf, input bit joint,
                         input bit gaps, input bit b2b, input string tag);
    int d0;
    int n;
    n = pk.size();
    start(s);
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " clr"}, {flags(), 32'(bus.bit_cnt)} == 64'd0 ? 32'd0 : 32'd1,
        32'd0);
    d0 = ndone;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.bit_in = 1'($urandom);
        tick();
      end
      bus.bit_valid = 1'b1;
      bus.bit_in = pk[i];
      bus.pkt_end = joint && (i == n - 1);
      tick();
      bus.bit_valid = 1'b0;
      bus.pkt_end = 1'b0;
    end
    if (!(joint && n > 0)) begin
      bus.pkt_end = 1'b1;
      tick();
      bus.pkt_end = 1'b0;
    end
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " ndone"}, 32'(ndone), 32'(d0 + 1));
    chk({tag, " busy0"}, 32'(bus.busy), 32'd0);
    chk({tag, " flags"}, flags(), expf);
    chk({tag, " cnt"}, 32'(bus.bit_cnt), 32'(ncnt));
    if (!b2b) begin
      for (int k = 0; k < 2; k++) begin
        bus.bit_valid = 1'($urandom);
        bus.bit_in = 1'($urandom);
        bus.pkt_end = 1'($urandom);
        tick();
        bus.bit_valid = 1'b0;
        bus.pkt_end = 1'b0;
      end
      chk({tag, " pulse"}, 32'(bus.done), 32'd0);
      chk({tag, " hold"}, {flags()[2:0], 29'(bus.bit_cnt)},
          {expf[2:0], 29'(ncnt)});
    end
  endtask

  initial begin
    int kind, nb, n, good;
    logic [2:0] s;
    logic [2:0] bad_sel [5];
    bad_sel = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    rst_n = 1'b0;
    bus.pkt_start = 1'b0;
    bus.sel = 3'b000;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0;
    bus.pkt_end = 1'b0;
    tick();
    tick();
    chk("reset outs", {26'd0, bus.busy, bus.done, flags()[2:0]} |
        32'(bus.bit_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle outs", {26'd0, bus.busy, bus.done, flags()[2:0]} |
        32'(bus.bit_cnt), 32'd0);

    // SETUP addr0 ep0
    pk.delete();
    push_byte(8'h00);
    push_byte(8'h10);
    run_pkt(3'b001, 16, 32'b100, 1'b0, 1'b0, 1'b0, "tok");
    pk[3] = ~pk[3];
    run_pkt(3'b001, 16, 32'b010, 1'b1, 1'b0, 1'b0, "tokbad");

    pk.delete();
    for (int i = 0; i < 16; i++) pk.push_back(1'b0);
    run_pkt(3'b010, 16, 32'b100, 1'b0, 1'b0, 1'b0, "zlp");
    pk.push_back(1'b0);
    run_pkt(3'b010, 17, 32'b001, 1'b1, 1'b0, 1'b0, "zlp17");

    pk.delete();
    run_pkt(3'b100, 0, 32'b100, 1'b0, 1'b0, 1'b0, "hs");
    pk.push_back(1'b1);
    run_pkt(3'b100, 1, 32'b001, 1'b1, 1'b0, 1'b0, "hs1");

    // abort a data packet by a fresh pkt_start
    n = ndone;
    start(3'b010);
    for (int i = 0; i < 10; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in = 1'($urandom);
      tick();
    end
    bus.bit_valid = 1'b0;
    gen_token(11'($urandom));
    run_pkt(3'b001, 16, 32'b100, 1'b1, 1'b1, 1'b0, "abort");
    chk("abort ndone", 32'(ndone), 32'(n + 1));

    // reset in the middle of a packet
    start(3'b010);
    for (int i = 0; i < 5; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid rst", {26'd0, bus.busy, bus.done, flags()[2:0]} |
        32'(bus.bit_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pk.delete();
    for (int i = 0; i < 16; i++) pk.push_back(1'($urandom));
    run_pkt(3'b011, 16, 32'b001, 1'b0, 1'b0, 1'b0, "sel011");

    // max and oversize payloads, then counter saturation
    gen_data(1023);
    run_pkt(3'b010, 8200, 32'b100, 1'b1, 1'b0, 1'b0, "max");
    gen_data(1024);
    run_pkt(3'b010, 8208, 32'b001, 1'b0, 1'b0, 1'b0, "over");
    pk.delete();
    for (int i = 0; i < 16400; i++) pk.push_back(1'b0);
    run_pkt(3'b010, 16383, 32'b001, 1'b1, 1'b0, 1'b0, "sat");

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 7);
      good = 1;
      s = 3'b001;
      case (kind)
        0: gen_token(11'($urandom));
        1: begin
          gen_token(11'($urandom));
          flip($urandom_range(1, 2));
          good = 0;
        end
        2: begin
          s = 3'b010;
          gen_data($urandom_range(0, 6));
        end
        3: begin
          s = 3'b010;
          gen_data($urandom_range(0, 6));
          flip($urandom_range(1, 2));
          good = 0;
        end
        4: begin
          s = 3'b010;
          gen_data($urandom_range(0, 6));
          nb = $urandom_range(1, 7);
          if ($urandom_range(0, 1) == 1)
            repeat (nb) pk.push_back(1'($urandom));
          else
            repeat (nb) void'(pk.pop_back());
        end
        5: begin
          s = 3'b100;
          pk.delete();
        end
        6: begin
          s = 3'b100;
          pk.delete();
          repeat ($urandom_range(1, 3)) pk.push_back(1'($urandom));
        end
        default: begin
          s = bad_sel[$urandom_range(0, 4)];
          pk.delete();
          repeat ($urandom_range(0, 20)) pk.push_back(1'($urandom));
        end
      endcase
      n = pk.size();
      run_pkt(s, n, model(s, n, good == 1), 1'($urandom),
              1'($urandom), ($urandom_range(0, 3) == 0), "rnd");
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
